// File: rtl/flag_branch_ctrl_pkg.sv
// Shared definitions for the flag register and branch condition decoder.
package flag_branch_ctrl_pkg;

    localparam int unsigned COND_W = 3;
    localparam int unsigned FLAG_W = 4;

    localparam logic [COND_W-1:0] COND_ALWAYS = 3'd0;
    localparam logic [COND_W-1:0] COND_EQ     = 3'd1;
    localparam logic [COND_W-1:0] COND_NE     = 3'd2;
    localparam logic [COND_W-1:0] COND_CS     = 3'd3;
    localparam logic [COND_W-1:0] COND_CC     = 3'd4;
    localparam logic [COND_W-1:0] COND_MI     = 3'd5;
    localparam logic [COND_W-1:0] COND_PL     = 3'd6;
    localparam logic [COND_W-1:0] COND_VS     = 3'd7;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    // Assemble a flag vector in the shared index order.
    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic z,
        input logic n,
        input logic c,
        input logic v
    );
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/flag_branch_ctrl_cond_eval.sv
// Combinational branch condition decoder: flag vector + condition code -> take.
module flag_cond_eval
    import flag_branch_ctrl_pkg::*;
(
    input  logic [FLAG_W-1:0] i_flags,
    input  logic [COND_W-1:0] i_cond,
    output logic              o_take_c
);

    always_comb begin
        o_take_c = 1'b0;
        case (i_cond)
            COND_ALWAYS: o_take_c = 1'b1;
            COND_EQ:     o_take_c = i_flags[FLAG_Z];
            COND_NE:     o_take_c = ~i_flags[FLAG_Z];
            COND_CS:     o_take_c = i_flags[FLAG_C];
            COND_CC:     o_take_c = ~i_flags[FLAG_C];
            COND_MI:     o_take_c = i_flags[FLAG_N];
            COND_PL:     o_take_c = ~i_flags[FLAG_N];
            COND_VS:     o_take_c = i_flags[FLAG_V];
            default:     o_take_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Status flag register and program counter with conditional branch resolution.
module flag_branch_ctrl
    import flag_branch_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_carry,
    input  logic              i_alu_ovf,
    input  logic              i_flag_we,
    input  logic              i_br_valid,
    input  logic [COND_W-1:0] i_br_cond,
    input  logic [PC_W-1:0]   i_br_target,
    input  logic              i_stall,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_flag_z,
    output logic              o_flag_n,
    output logic              o_flag_c,
    output logic              o_flag_v,
    output logic              o_br_taken
);

    logic [FLAG_W-1:0] r_flags;
    logic [PC_W-1:0]   r_pc;
    logic              r_br_taken;

    logic [FLAG_W-1:0] w_new_flags;
    logic [FLAG_W-1:0] w_eval_flags;
    logic              w_take;

    assign w_new_flags = pack_flags(~|i_alu_result, i_alu_result[DATA_W-1],
                                    i_alu_carry, i_alu_ovf);

    // Same-cycle flag write is forwarded so the branch sees this op's result.
    assign w_eval_flags = i_flag_we ? w_new_flags : r_flags;

    flag_cond_eval u_cond_eval (
        .i_flags  (w_eval_flags),
        .i_cond   (i_br_cond),
        .o_take_c (w_take)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flags    <= '0;
            r_pc       <= PC_W'(RESET_PC);
            r_br_taken <= 1'b0;
        end else if (i_stall) begin
            r_br_taken <= 1'b0;
        end else begin
            if (i_flag_we) begin
                r_flags <= w_new_flags;
            end
            if (i_br_valid && w_take) begin
                r_pc       <= i_br_target;
                r_br_taken <= 1'b1;
            end else begin
                r_pc       <= r_pc + PC_W'(1);
                r_br_taken <= 1'b0;
            end
        end
    end

    assign o_pc       = r_pc;
    assign o_flag_z   = r_flags[FLAG_Z];
    assign o_flag_n   = r_flags[FLAG_N];
    assign o_flag_c   = r_flags[FLAG_C];
    assign o_flag_v   = r_flags[FLAG_V];
    assign o_br_taken = r_br_taken;

endmodule
